// File: rtl/bus_timer_irq.sv
// bus_timer_irq
// Memory-mapped 16-bit down-counting timer for the cpu6502 bus. It sits in an
// 8-byte register window next to the SRAM, drives a level interrupt (irq_n)
// and a fixed-length NMI pulse (nmi_n). Read data is purely combinational so
// the top level can mux it into the CPU data_in using 'selected'.
//
// Register map (offset = address[2:0]):
//   0 CTRL      rw   [0]run [1]irq_en [2]auto_reload [3]nmi_sel
//   1 STATUS    w1c  [0]expired
//   2 RELOAD_LO rw
//   3 RELOAD_HI rw   writing also loads count <= {data, RELOAD_LO}
//   4 COUNT_LO  ro
//   5 COUNT_HI  ro
//   6,7         read 0xFF, writes ignored
//
// Bus handshake: a write commits on the clk edge where
// bus_strobe & selected & !read_not_write; reads never change state.
module bus_timer_irq #(
    parameter logic [15:0] BASE_ADDRESS = 16'hFF00,
    parameter logic [7:0]  PRESCALE     = 8'd15,
    parameter logic [3:0]  NMI_PULSE    = 4'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_strobe,
    input  logic [15:0] address,
    input  logic        read_not_write,
    input  logic [7:0]  write_data,
    output logic        selected,
    output logic [7:0]  read_data,
    output logic        irq_n,
    output logic        nmi_n
);

    localparam logic [2:0] OFF_CTRL      = 3'd0;
    localparam logic [2:0] OFF_STATUS    = 3'd1;
    localparam logic [2:0] OFF_RELOAD_LO = 3'd2;
    localparam logic [2:0] OFF_RELOAD_HI = 3'd3;
    localparam logic [2:0] OFF_COUNT_LO  = 3'd4;
    localparam logic [2:0] OFF_COUNT_HI  = 3'd5;

    // Architectural state
    logic        ctrl_run;
    logic        ctrl_irq_en;
    logic        ctrl_auto_reload;
    logic        ctrl_nmi_sel;
    logic        expired;
    logic [15:0] reload;
    logic [15:0] count;
    logic [7:0]  prescaler;
    logic [3:0]  nmi_timer;

    // Decoded bus writes
    logic        wr_en;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_reload_lo;
    logic        wr_reload_hi;

    // Timer events
    logic        tick;
    logic        tick_live;
    logic        expire;

    assign selected     = (address[15:3] == BASE_ADDRESS[15:3]);
    assign wr_en        = bus_strobe & selected & ~read_not_write;
    assign wr_ctrl      = wr_en & (address[2:0] == OFF_CTRL);
    assign wr_status    = wr_en & (address[2:0] == OFF_STATUS);
    assign wr_reload_lo = wr_en & (address[2:0] == OFF_RELOAD_LO);
    assign wr_reload_hi = wr_en & (address[2:0] == OFF_RELOAD_HI);

    // A tick is raised when the prescaler wraps. A CPU write to CTRL or
    // RELOAD_HI in the same cycle takes priority, so the tick is dropped and
    // neither the count nor the expiry logic sees it.
    assign tick      = ctrl_run & (prescaler == PRESCALE);
    assign tick_live = tick & ~wr_ctrl & ~wr_reload_hi;
    assign expire    = tick_live & (count == 16'h0000);

    // Prescaler: counts 0..PRESCALE while running, held at 0 while stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= 8'd0;
        end else if (!ctrl_run) begin
            prescaler <= 8'd0;
        end else if (prescaler == PRESCALE) begin
            prescaler <= 8'd0;
        end else begin
            prescaler <= prescaler + 8'd1;
        end
    end

    // CTRL register; a one-shot expiry stops the timer unless CTRL is being written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_run         <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_nmi_sel     <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_run         <= write_data[0];
            ctrl_irq_en      <= write_data[1];
            ctrl_auto_reload <= write_data[2];
            ctrl_nmi_sel     <= write_data[3];
        end else if (expire && !ctrl_auto_reload) begin
            ctrl_run         <= 1'b0;
        end
    end

    // STATUS.expired: set on expiry, cleared by writing 1; set wins a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (wr_status && write_data[0]) begin
            expired <= 1'b0;
        end
    end

    // RELOAD register, written a byte at a time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload <= 16'hFFFF;
        end else begin
            if (wr_reload_lo) begin
                reload[7:0] <= write_data;
            end
            if (wr_reload_hi) begin
                reload[15:8] <= write_data;
            end
        end
    end

    // Down counter: loaded by RELOAD_HI writes, decremented on ticks, and on
    // expiry either reloaded or parked at zero (never wraps below 0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 16'hFFFF;
        end else if (wr_reload_hi) begin
            count <= {write_data, reload[7:0]};
        end else if (tick_live) begin
            if (count != 16'h0000) begin
                count <= count - 16'd1;
            end else if (ctrl_auto_reload) begin
                count <= reload;
            end
        end
    end

    // NMI pulse timer: reloaded on each NMI expiry (extending a live pulse),
    // otherwise runs down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_timer <= 4'd0;
        end else if (expire && ctrl_nmi_sel) begin
            nmi_timer <= NMI_PULSE;
        end else if (nmi_timer != 4'd0) begin
            nmi_timer <= nmi_timer - 4'd1;
        end
    end

    assign irq_n = ~(expired & ctrl_irq_en & ~ctrl_nmi_sel);
    assign nmi_n = (nmi_timer == 4'd0);

    // Combinational read mux; zero whenever the window is not addressed.
    always_comb begin
        read_data = 8'h00;
        if (selected) begin
            case (address[2:0])
                OFF_CTRL:      read_data = {4'b0000, ctrl_nmi_sel, ctrl_auto_reload,
                                            ctrl_irq_en, ctrl_run};
                OFF_STATUS:    read_data = {7'b0000000, expired};
                OFF_RELOAD_LO: read_data = reload[7:0];
                OFF_RELOAD_HI: read_data = reload[15:8];
                OFF_COUNT_LO:  read_data = count[7:0];
                OFF_COUNT_HI:  read_data = count[15:8];
                default:       read_data = 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_timer_irq.sv
// tb_bus_timer_irq
// Directed bench for bus_timer_irq with PRESCALE=0 (one tick per clk while
// running) and NMI_PULSE=4. Expected values are hand-computed cycle by cycle
// from the clk edge on which the enabling CTRL write commits.
`timescale 1ns/1ps
module tb_bus_timer_irq;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk;
    logic        reset;
    logic        bus_strobe;
    logic [15:0] address;
    logic        read_not_write;
    logic [7:0]  write_data;
    logic        selected;
    logic [7:0]  read_data;
    logic        irq_n;
    logic        nmi_n;

    int total;
    int bad;

    bus_timer_irq #(
        .BASE_ADDRESS(BASE),
        .PRESCALE(8'd0),
        .NMI_PULSE(4'd4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus_strobe(bus_strobe),
        .address(address),
        .read_not_write(read_not_write),
        .write_data(write_data),
        .selected(selected),
        .read_data(read_data),
        .irq_n(irq_n),
        .nmi_n(nmi_n)
    );

    // Clock: 100 ns period, leaves room for several combinational reads per cycle.
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single bus write, committing on the next rising edge.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address        = a;
        write_data     = d;
        read_not_write = 1'b0;
        bus_strobe     = 1'b1;
        @(posedge clk);
        #1;
        bus_strobe     = 1'b0;
        read_not_write = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] off, input logic [7:0] exp);
        address = BASE | {13'd0, off};
        #1;
        chk(tag, {8'h00, read_data}, {8'h00, exp});
    endtask

    task automatic chk_count(input string tag, input logic [15:0] exp);
        logic [15:0] c;
        address = BASE | 16'd4;
        #1;
        c[7:0] = read_data;
        address = BASE | 16'd5;
        #1;
        c[15:8] = read_data;
        chk(tag, c, exp);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        bus_strobe     = 1'b0;
        address        = BASE;
        read_not_write = 1'b1;
        write_data     = 8'h00;

        // 1. Reset state
        #20;
        chk("rst_irq_n", {15'd0, irq_n}, 16'd1);
        chk("rst_nmi_n", {15'd0, nmi_n}, 16'd1);
        chk("rst_selected", {15'd0, selected}, 16'd1);
        chk_reg("rst_ctrl", 3'd0, 8'h00);
        chk_reg("rst_status", 3'd1, 8'h00);
        chk_reg("rst_reload_lo", 3'd2, 8'hFF);
        chk_reg("rst_reload_hi", 3'd3, 8'hFF);
        chk_reg("rst_off6", 3'd6, 8'hFF);
        chk_count("rst_count", 16'hFFFF);
        @(negedge clk);
        reset = 1'b0;

        // 2. Auto-reload with irq: RELOAD=3, CTRL=0x07
        bus_write(BASE | 16'd2, 8'h03);
        bus_write(BASE | 16'd3, 8'h00);
        chk_count("t2_load", 16'h0003);
        bus_write(BASE | 16'd0, 8'h07);
        chk("t2_irq_c0", {15'd0, irq_n}, 16'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("t2_irq_c%0d", k), {15'd0, irq_n}, 16'd1);
        end
        chk_count("t2_count_c3", 16'h0000);
        step();
        chk("t2_irq_c4", {15'd0, irq_n}, 16'd0);
        chk_reg("t2_status_c4", 3'd1, 8'h01);
        chk_count("t2_reloaded", 16'h0003);
        bus_write(BASE | 16'd1, 8'h01);
        chk("t2_irq_cleared", {15'd0, irq_n}, 16'd1);
        chk_reg("t2_status_cleared", 3'd1, 8'h00);
        chk_count("t2_count_c5", 16'h0002);
        // CTRL write collides with a tick: count must hold at 2
        bus_write(BASE | 16'd0, 8'h00);
        chk_count("t2_stop_wins", 16'h0002);
        chk_reg("t2_ctrl_off", 3'd0, 8'h00);
        step();
        chk_count("t2_stopped_hold", 16'h0002);

        // 3. One-shot: RELOAD=2, CTRL=0x01
        bus_write(BASE | 16'd2, 8'h02);
        bus_write(BASE | 16'd3, 8'h00);
        bus_write(BASE | 16'd0, 8'h01);
        step();
        chk_count("t3_count_c1", 16'h0001);
        step();
        chk_count("t3_count_c2", 16'h0000);
        chk_reg("t3_ctrl_c2", 3'd0, 8'h01);
        step();
        chk_reg("t3_ctrl_c3", 3'd0, 8'h00);
        chk_reg("t3_status_c3", 3'd1, 8'h01);
        chk_count("t3_count_c3", 16'h0000);
        chk("t3_irq_n", {15'd0, irq_n}, 16'd1);
        step();
        step();
        chk_count("t3_count_parked", 16'h0000);

        // 5. Clear collides with expiry; out-of-window writes
        bus_write(BASE | 16'd1, 8'h01);
        chk_reg("t5_status_pre", 3'd1, 8'h00);
        bus_write(BASE | 16'd2, 8'h02);
        bus_write(BASE | 16'd3, 8'h00);
        bus_write(BASE | 16'd0, 8'h05);
        step();
        step();
        bus_write(BASE | 16'd1, 8'h01);
        chk_reg("t5_set_wins", 3'd1, 8'h01);
        chk_count("t5_reload", 16'h0002);
        bus_write(16'hFE00, 8'h00);
        bus_write(16'h0003, 8'h55);
        bus_write(BASE | 16'd6, 8'h00);
        address = 16'hFE00;
        #1;
        chk("t5_unselected", {15'd0, selected}, 16'd0);
        chk("t5_unsel_data", {8'h00, read_data}, 16'h0000);
        chk_reg("t5_ctrl_kept", 3'd0, 8'h05);
        chk_reg("t5_reload_lo_kept", 3'd2, 8'h02);
        chk_reg("t5_reload_hi_kept", 3'd3, 8'h00);
        chk_reg("t5_off6_kept", 3'd6, 8'hFF);
        chk_reg("t5_off7", 3'd7, 8'hFF);
        bus_write(BASE | 16'd0, 8'h00);

        // 4. NMI mode: RELOAD=7, CTRL=0x0D -> expiry every 8 clks, 4-clk pulse
        bus_write(BASE | 16'd1, 8'h01);
        bus_write(BASE | 16'd2, 8'h07);
        bus_write(BASE | 16'd3, 8'h00);
        bus_write(BASE | 16'd0, 8'h0D);
        for (int k = 1; k <= 16; k++) begin
            logic exp_nmi;
            step();
            exp_nmi = ((k >= 8 && k <= 11) || k == 16) ? 1'b0 : 1'b1;
            chk($sformatf("t4_nmi_c%0d", k), {15'd0, nmi_n}, {15'd0, exp_nmi});
            chk($sformatf("t4_irq_c%0d", k), {15'd0, irq_n}, 16'd1);
        end

        // 6. Reset mid-pulse, mid-count
        step();
        chk("t6_nmi_low", {15'd0, nmi_n}, 16'd0);
        chk_count("t6_count_mid", 16'h0006);
        reset = 1'b1;
        #1;
        chk("t6_nmi_rst", {15'd0, nmi_n}, 16'd1);
        chk("t6_irq_rst", {15'd0, irq_n}, 16'd1);
        chk_count("t6_count_rst", 16'hFFFF);
        chk_reg("t6_ctrl_rst", 3'd0, 8'h00);
        chk_reg("t6_status_rst", 3'd1, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_count("t6_count_idle", 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
